// File: rtl/ram_arbiter_if.sv
// Bundle of the fetch, data and memory port signals around ram_arbiter.
// slave is the arbiter's view; master is the core/memory side.
interface ram_arbiter_if;
  logic        i_ren;
  logic [31:0] i_addr;
  logic [31:0] i_load;
  logic [1:0]  i_state;
  logic        d_ren;
  logic [3:0]  d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_store;
  logic [31:0] d_load;
  logic [1:0]  d_state;
  logic        m_ren;
  logic [3:0]  m_wen;
  logic [31:0] m_addr;
  logic [31:0] m_store;
  logic [31:0] m_load;
  logic [1:0]  m_state;

  modport slave (
    input  i_ren, i_addr, d_ren, d_wen, d_addr, d_store, m_load, m_state,
    output i_load, i_state, d_load, d_state, m_ren, m_wen, m_addr, m_store
  );
  modport master (
    output i_ren, i_addr, d_ren, d_wen, d_addr, d_store, m_load, m_state,
    input  i_load, i_state, d_load, d_state, m_ren, m_wen, m_addr, m_store
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester (fetch/data) arbiter for one single-port memory, zero added latency.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break instead of fixed DATA_PRIO.
module ram_arbiter #(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {RAM_IDLE = 2'd0, RAM_WAIT = 2'd1, RAM_DONE = 2'd2} ram_state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_t;

  owner_t owner, sel;
  logic   i_req, d_req, d_win, own_req;

  assign i_req = bus.i_ren;
  assign d_req = bus.d_ren | (|bus.d_wen);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;  // 1 when D received the most recent grant
  assign d_win = ~last_d;
`else
  assign d_win = DATA_PRIO;
`endif

  // Arbitrate only when idle; an owner keeps the port until DONE or it withdraws.
  always_comb begin
    sel = owner;
    if (owner == OWN_NONE) begin
      if (i_req && d_req) sel = d_win ? OWN_D : OWN_I;
      else if (d_req)     sel = OWN_D;
      else if (i_req)     sel = OWN_I;
    end
    if (rst) sel = OWN_NONE;
  end

  assign own_req = (sel == OWN_I) ? i_req : (sel == OWN_D) ? d_req : 1'b0;

  always_comb begin
    bus.m_ren   = 1'b0;
    bus.m_wen   = 4'h0;
    bus.m_addr  = 32'h0;
    bus.m_store = 32'h0;
    bus.i_state = i_req ? RAM_WAIT : RAM_IDLE;
    bus.d_state = d_req ? RAM_WAIT : RAM_IDLE;
    case (sel)
      OWN_I: begin
        bus.m_ren   = bus.i_ren;
        bus.m_addr  = bus.i_addr;
        bus.i_state = bus.m_state;
      end
      OWN_D: begin
        bus.m_ren   = bus.d_ren;
        bus.m_wen   = bus.d_wen;
        bus.m_addr  = bus.d_addr;
        bus.m_store = bus.d_store;
        bus.d_state = bus.m_state;
      end
      default: ;
    endcase
    if (rst) begin
      bus.i_state = RAM_IDLE;
      bus.d_state = RAM_IDLE;
    end
  end

  assign bus.i_load = bus.m_load;
  assign bus.d_load = bus.m_load;

  always_ff @(posedge clk) begin
    if (rst)
      owner <= OWN_NONE;
    else if (sel == OWN_NONE || bus.m_state == RAM_DONE || !own_req)
      owner <= OWN_NONE;
    else
      owner <= sel;
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)
      last_d <= 1'b0;
    else if (owner == OWN_NONE && sel != OWN_NONE)
      last_d <= (sel == OWN_D);
  end
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (DATA_PRIO=1 and 0) with identical stimulus,
// each behind its own memory model, checked every cycle against a behavioural model.
module tb_ram_arbiter;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;

  logic clk, rst;
  int   lat;
  int   errors, checks;

  logic [1:0]  i_pend, d_pend, idrop, ddrop;
  logic        d_rd, hold;
  logic [3:0]  d_wen_v;
  logic [31:0] i_addr_v, d_addr_v, d_store_v;

  logic [1:0]        o_mr;
  logic [1:0][3:0]   o_mw;
  logic [1:0][1:0]   o_is, o_ds, o_mst;
  logic [1:0][31:0]  o_il, o_dl, o_ma, o_ms, o_mld;

  int mh [2];  // model owner: 0 none, 1 I, 2 D
`ifdef ARB_ROUND_ROBIN_EN
  bit mlast_d [2];
`endif

  ram_arbiter_if bus [2] ();

  for (genvar k = 0; k < 2; k++) begin : g
    ram_arbiter #(.DATA_PRIO(k == 0)) u_dut (.clk(clk), .rst(rst), .bus(bus[k]));

    assign bus[k].i_ren   = i_pend[k];
    assign bus[k].i_addr  = i_addr_v;
    assign bus[k].d_ren   = d_pend[k] & d_rd;
    assign bus[k].d_wen   = d_pend[k] ? d_wen_v : 4'h0;
    assign bus[k].d_addr  = d_addr_v;
    assign bus[k].d_store = d_store_v;

    // Memory: LAT+1 cycles of WAIT then one DONE; write lands on the DONE edge.
    logic [31:0] mem [64];
    int   cnt;
    logic mreq;
    assign mreq = bus[k].m_ren | (|bus[k].m_wen);
    assign bus[k].m_state = !mreq ? IDLE : (cnt > lat) ? DONE : WAIT;
    assign bus[k].m_load  = (mreq && cnt > lat) ? mem[bus[k].m_addr[7:2]] : 32'h0;
    always @(posedge clk) begin
      if (rst) begin
        cnt <= 0;
        for (int j = 0; j < 64; j++) mem[j] <= 32'hA500_0000 | j;
      end else begin
        cnt <= (!mreq || cnt > lat) ? 0 : cnt + 1;
        if (mreq && cnt > lat)
          for (int b = 0; b < 4; b++)
            if (bus[k].m_wen[b]) mem[bus[k].m_addr[7:2]][8*b +: 8] <= bus[k].m_store[8*b +: 8];
      end
    end

    assign o_mr[k]  = bus[k].m_ren;
    assign o_mw[k]  = bus[k].m_wen;
    assign o_ma[k]  = bus[k].m_addr;
    assign o_ms[k]  = bus[k].m_store;
    assign o_is[k]  = bus[k].i_state;
    assign o_ds[k]  = bus[k].d_state;
    assign o_il[k]  = bus[k].i_load;
    assign o_dl[k]  = bus[k].d_load;
    assign o_mst[k] = bus[k].m_state;
    assign o_mld[k] = bus[k].m_load;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs from the sharing rules: who holds the port, what it sees, what the other sees.
  task automatic model_chk();
    for (int k = 0; k < 2; k++) begin
      logic ir, dr, dwin, er, oreq;
      int who;
      logic [31:0] ea, es;
      logic [3:0]  ew;
      logic [1:0]  eis, eds;
      ir = i_pend[k];
      dr = d_pend[k] & (d_rd | (|d_wen_v));
`ifdef ARB_ROUND_ROBIN_EN
      dwin = !mlast_d[k];
`else
      dwin = (k == 0);
`endif
      who = mh[k];
      if (who == 0) who = (ir && dr) ? (dwin ? 2 : 1) : dr ? 2 : ir ? 1 : 0;
      if (rst) who = 0;
      er = 1'b0; ew = 4'h0; ea = 32'h0; es = 32'h0;
      eis = ir ? WAIT : IDLE;
      eds = dr ? WAIT : IDLE;
      if (who == 1) begin
        er = ir; ea = i_addr_v; eis = o_mst[k];
      end else if (who == 2) begin
        er = d_pend[k] & d_rd; ew = d_pend[k] ? d_wen_v : 4'h0;
        ea = d_addr_v; es = d_store_v; eds = o_mst[k];
      end
      if (rst) begin eis = IDLE; eds = IDLE; end
      chk($sformatf("m_ren[%0d]", k),   {31'h0, o_mr[k]}, {31'h0, er});
      chk($sformatf("m_wen[%0d]", k),   {28'h0, o_mw[k]}, {28'h0, ew});
      chk($sformatf("m_addr[%0d]", k),  o_ma[k], ea);
      chk($sformatf("m_store[%0d]", k), o_ms[k], es);
      chk($sformatf("i_state[%0d]", k), {30'h0, o_is[k]}, {30'h0, eis});
      chk($sformatf("d_state[%0d]", k), {30'h0, o_ds[k]}, {30'h0, eds});
      if (eis == DONE) chk($sformatf("i_load[%0d]", k), o_il[k], o_mld[k]);
      if (eds == DONE) chk($sformatf("d_load[%0d]", k), o_dl[k], o_mld[k]);
      oreq = (who == 1) ? ir : dr;
`ifdef ARB_ROUND_ROBIN_EN
      if (!rst && mh[k] == 0 && who != 0) mlast_d[k] = (who == 2);
`endif
      mh[k] = (who == 0 || o_mst[k] == DONE || !oreq) ? 0 : who;
    end
  endtask

  // Check phase: outputs settled mid-cycle.
  task automatic cyc_chk();
    @(negedge clk);
    model_chk();
    for (int k = 0; k < 2; k++) begin
      if (!hold && o_is[k] == DONE) idrop[k] = 1'b1;
      if (!hold && o_ds[k] == DONE) ddrop[k] = 1'b1;
    end
  endtask

  // Drive phase: requesters withdraw after their own DONE.
  task automatic adv();
    @(posedge clk);
    #1;
    i_pend &= ~idrop;
    d_pend &= ~ddrop;
    idrop = 2'b00;
    ddrop = 2'b00;
  endtask

  initial begin
    int idc [2], ddc [2], in_ [2], dn [2];
    errors = 0; checks = 0;
    idrop = 2'b00; ddrop = 2'b00; hold = 1'b0; lat = 0;
    mh[0] = 0; mh[1] = 0;
`ifdef ARB_ROUND_ROBIN_EN
    mlast_d[0] = 1'b0; mlast_d[1] = 1'b0;
`endif
    // Reset with both requesters active: port must stay quiet.
    rst = 1'b1; i_pend = 2'b11; d_pend = 2'b11; d_rd = 1'b1; d_wen_v = 4'hF;
    i_addr_v = 32'h4; d_addr_v = 32'h8; d_store_v = 32'h0;
    cyc_chk();
    chk("rst_m_ren", {31'h0, o_mr[0]}, 32'h0);
    chk("rst_m_wen", {28'h0, o_mw[0]}, 32'h0);
    chk("rst_i_state", {30'h0, o_is[0]}, {30'h0, IDLE});
    chk("rst_d_state", {30'h0, o_ds[1]}, {30'h0, IDLE});
    adv();
    rst = 1'b0; i_pend = 2'b00; d_pend = 2'b00; d_wen_v = 4'h0;
    cyc_chk(); adv();

    // Single fetch, LAT=0.
    i_addr_v = 32'h10; i_pend = 2'b11;
    cyc_chk();
    for (int k = 0; k < 2; k++) begin
      chk("t1_m_ren", {31'h0, o_mr[k]}, 32'h1);
      chk("t1_m_addr", o_ma[k], 32'h10);
    end
    adv(); cyc_chk();
    for (int k = 0; k < 2; k++) begin
      chk("t1_i_done", {30'h0, o_is[k]}, {30'h0, DONE});
      chk("t1_i_load", o_il[k], 32'hA500_0004);
      chk("t1_d_idle", {30'h0, o_ds[k]}, {30'h0, IDLE});
    end
    adv(); cyc_chk(); adv();

    // Simultaneous D partial write and I fetch.
    i_addr_v = 32'h14; i_pend = 2'b11;
    d_addr_v = 32'h20; d_wen_v = 4'b0011; d_store_v = 32'hAABB_CCDD; d_rd = 1'b0; d_pend = 2'b11;
    idc[0] = -1; idc[1] = -1; ddc[0] = -1; ddc[1] = -1;
    for (int c = 0; c < 5; c++) begin
      cyc_chk();
      for (int k = 0; k < 2; k++) begin
        if (o_is[k] == DONE && idc[k] < 0) idc[k] = c;
        if (o_ds[k] == DONE && ddc[k] < 0) ddc[k] = c;
      end
      if (c < 2) chk("t2_i_wait", {30'h0, o_is[0]}, {30'h0, WAIT});
      adv();
    end
    chk("t2_d_done_cyc", ddc[0], 1);
    chk("t2_i_done_cyc", idc[0], 3);
`ifdef ARB_ROUND_ROBIN_EN
    chk("t3_d_done_cyc", ddc[1], 1);
    chk("t3_i_done_cyc", idc[1], 3);
`else
    chk("t3_i_done_cyc", idc[1], 1);
    chk("t3_d_done_cyc", ddc[1], 3);
`endif
    chk("t2_mem8", g[0].mem[8], 32'hA500_CCDD);
    chk("t3_mem8", g[1].mem[8], 32'hA500_CCDD);
    d_wen_v = 4'h0; cyc_chk(); adv();

    // Both requesting continuously for 8 cycles.
    hold = 1'b1; d_rd = 1'b1; d_addr_v = 32'h24; i_addr_v = 32'h18;
    i_pend = 2'b11; d_pend = 2'b11;
    in_[0] = 0; in_[1] = 0; dn[0] = 0; dn[1] = 0;
    for (int c = 0; c < 8; c++) begin
      cyc_chk();
      for (int k = 0; k < 2; k++) begin
        if (o_is[k] == DONE) in_[k]++;
        if (o_ds[k] == DONE) dn[k]++;
      end
      adv();
    end
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 2; k++) begin
      chk("t4_i_dones", in_[k], 2);
      chk("t4_d_dones", dn[k], 2);
    end
`else
    chk("t4_i_dones0", in_[0], 0);
    chk("t4_d_dones0", dn[0], 4);
    chk("t4_i_dones1", in_[1], 4);
    chk("t4_d_dones1", dn[1], 0);
`endif
    hold = 1'b0; i_pend = 2'b00; d_pend = 2'b00;
    cyc_chk(); adv();

    // D owner withdraws mid-WAIT (LAT=2); pending I granted right after.
    lat = 2; d_addr_v = 32'h28; d_rd = 1'b1; d_pend = 2'b11;
    cyc_chk(); adv();
    i_addr_v = 32'h18; i_pend = 2'b11;
    cyc_chk();
    chk("t6_i_wait", {30'h0, o_is[0]}, {30'h0, WAIT});
    adv();
    d_pend = 2'b00;
    cyc_chk();
    chk("t6_m_ren_drop", {31'h0, o_mr[1]}, 32'h0);
    adv(); cyc_chk();
    for (int k = 0; k < 2; k++) begin
      chk("t6_i_grant", {31'h0, o_mr[k]}, 32'h1);
      chk("t6_i_addr", o_ma[k], 32'h18);
    end
    adv(); cyc_chk(); adv(); cyc_chk(); adv(); cyc_chk();
    chk("t6_i_done", {30'h0, o_is[0]}, {30'h0, DONE});
    chk("t6_i_load", o_il[0], 32'hA500_0006);
    adv(); cyc_chk(); adv();

    // Reset in the middle of a D write (LAT=2); write must never land.
    d_rd = 1'b0; d_wen_v = 4'hF; d_addr_v = 32'h2C; d_store_v = 32'h1234_5678; d_pend = 2'b11;
    cyc_chk();
    chk("t5_m_wen", {28'h0, o_mw[0]}, 32'hF);
    adv();
    rst = 1'b1; i_pend = 2'b11;
    cyc_chk();
    for (int k = 0; k < 2; k++) begin
      chk("t5_rst_m_ren", {31'h0, o_mr[k]}, 32'h0);
      chk("t5_rst_m_wen", {28'h0, o_mw[k]}, 32'h0);
      chk("t5_rst_i_idle", {30'h0, o_is[k]}, {30'h0, IDLE});
      chk("t5_rst_d_idle", {30'h0, o_ds[k]}, {30'h0, IDLE});
    end
    adv();
    rst = 1'b0; d_pend = 2'b00; d_wen_v = 4'h0;
    cyc_chk();
    for (int k = 0; k < 2; k++) begin
      chk("t5_i_grant", {31'h0, o_mr[k]}, 32'h1);
      chk("t5_i_addr", o_ma[k], 32'h18);
    end
    for (int c = 0; c < 5; c++) begin adv(); cyc_chk(); end
    chk("t5_no_write", g[0].mem[11], 32'hA500_000B);
    adv();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
